// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the register-file write arbiter.
//   wb_entry_t  : one long-latency FIFO slot {live, rd, data}
//   WB_X0       : index of the hard-wired zero register
//   WB_LL_DEPTH : default long-latency FIFO depth
// The entry struct is sized by WB_ADDR_WIDTH / WB_DATA_WIDTH, so the
// arbiter's ADDR_WIDTH / DATA_WIDTH parameters must match these values.
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_LL_DEPTH   = 4;

    localparam logic [WB_ADDR_WIDTH-1:0] WB_X0 = '0;

    typedef struct packed {
        logic                     live;
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter_if
// Bundles the pipeline writeback request, the long-latency result handshake
// and the register-file write stream (plus hazard-unit status).
//   master : arbiter view (consumes requests, drives write stream/status)
//   slave  : environment view (drives requests, observes outputs)
// ---------------------------------------------------------------------------
interface wb_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
);
    // pipeline writeback
    logic                          pipe_we;
    logic [ADDR_WIDTH-1:0]         pipe_rd;
    logic [DATA_WIDTH-1:0]         pipe_data;
    // long-latency results
    logic                          ll_valid;
    logic                          ll_ready;
    logic [ADDR_WIDTH-1:0]         ll_rd;
    logic [DATA_WIDTH-1:0]         ll_data;
    // register file write port
    logic                          reg_write_en;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0]         rd_data;
    // hazard-unit status
    logic [(2**ADDR_WIDTH)-1:0]    pending_mask;
    logic [$clog2(DEPTH):0]        fifo_count;

    modport master (
        input  pipe_we, pipe_rd, pipe_data,
        input  ll_valid, ll_rd, ll_data,
        output ll_ready,
        output reg_write_en, rd_addr, rd_data,
        output pending_mask, fifo_count
    );

    modport slave (
        output pipe_we, pipe_rd, pipe_data,
        output ll_valid, ll_rd, ll_data,
        input  ll_ready,
        input  reg_write_en, rd_addr, rd_data,
        input  pending_mask, fifo_count
    );
endinterface

// File: rtl/wb_ll_fifo.sv
// ---------------------------------------------------------------------------
// wb_ll_fifo
// Small FIFO for buffered long-latency results. Each entry carries a live
// bit that can be cleared in parallel by rd match (WAW squash).
// Optional feature macro: WB_ARB_PENDING_MASK_EN -- when defined, produces
// pending_mask (one-hot OR of rd over live entries); otherwise it is 0.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push/push_rd/_data  enqueue (new entry always live)
//   pop                 advance head (caller guarantees non-empty)
//   squash_en/rd        clear live bit of every entry whose rd matches
//   head                current head entry
//   count               occupancy 0..DEPTH
//   pending_mask        live-entry register mask
// ---------------------------------------------------------------------------
module wb_ll_fifo
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH      = WB_LL_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_WIDTH-1:0]      push_rd,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    input  logic                       squash_en,
    input  logic [ADDR_WIDTH-1:0]      squash_rd,
    output wb_entry_t                  head,
    output logic [$clog2(DEPTH):0]     count,
    output logic [(2**ADDR_WIDTH)-1:0] pending_mask
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREGS = 2**ADDR_WIDTH;

    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [DEPTH-1:0]      live_reg, live_next;
    logic [DEPTH-1:0]      match;
    logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    // Parallel rd comparators shared by the squash path.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = (rd_mem[gi] == squash_rd);
        end
    endgenerate

    // Squash first, then pop/push: squash sees pre-edge contents and a
    // freshly pushed entry is always live. Popped slots are cleared so a
    // live bit always implies an occupied slot.
    always_comb begin
        live_next = live_reg;
        if (squash_en) begin
            live_next = live_next & ~match;
        end
        if (pop) begin
            live_next[rd_ptr_reg] = 1'b0;
        end
        if (push) begin
            live_next[wr_ptr_reg] = 1'b1;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            live_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            live_reg  <= live_next;
        end
    end

    // Payload storage needs no reset: validity is carried by live_reg/count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= push_rd;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head.live = live_reg[rd_ptr_reg];
    assign head.rd   = rd_mem[rd_ptr_reg];
    assign head.data = data_mem[rd_ptr_reg];
    assign count     = count_reg;

`ifdef WB_ARB_PENDING_MASK_EN
    logic [NREGS-1:0] entry_mask [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
            assign entry_mask[gi] = live_reg[gi] ? (NREGS'(1) << rd_mem[gi]) : '0;
        end
    endgenerate

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_mask = pending_mask | entry_mask[i];
        end
    end
`else
    // Hazard unit stalls on count != 0 instead.
    assign pending_mask = '0;
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
// Single write-port master for the register file. The in-order pipeline
// writeback always wins; long-latency results are buffered in wb_ll_fifo
// and drained in free slots, bypassing the FIFO when it is empty.
// Pipe writes squash older buffered writes to the same register (WAW).
// Optional feature macro: WB_ARB_PENDING_MASK_EN (enables pending_mask).
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   wb_write_arbiter_if.master: pipe request, LL handshake,
//         registered reg_write_en/rd_addr/rd_data, pending_mask, fifo_count
// ---------------------------------------------------------------------------
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH      = WB_LL_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_write_arbiter_if.master   bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                       pipe_busy;
    logic                       ll_take;
    logic                       fifo_empty;
    logic                       ll_ready;

    logic                       push, pop, squash_en;
    wb_entry_t                  head;
    logic [CNT_W-1:0]           fifo_count;
    logic [(2**ADDR_WIDTH)-1:0] pending_mask;

    logic                       reg_write_en_reg, reg_write_en_next;
    logic [ADDR_WIDTH-1:0]      rd_addr_reg, rd_addr_next;
    logic [DATA_WIDTH-1:0]      rd_data_reg, rd_data_next;

    // Ready depends on registered occupancy only; a pop in the same cycle
    // does not open a slot.
    assign ll_ready   = (fifo_count < CNT_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign pipe_busy  = bus.pipe_we && (bus.pipe_rd != ADDR_WIDTH'(WB_X0));
    // x0 transfers complete the handshake but carry nothing.
    assign ll_take    = bus.ll_valid && ll_ready && (bus.ll_rd != ADDR_WIDTH'(WB_X0));

    always_comb begin
        push              = 1'b0;
        pop               = 1'b0;
        squash_en         = 1'b0;
        reg_write_en_next = 1'b0;
        rd_addr_next      = rd_addr_reg;
        rd_data_next      = rd_data_reg;
        if (pipe_busy) begin
            reg_write_en_next = 1'b1;
            rd_addr_next      = bus.pipe_rd;
            rd_data_next      = bus.pipe_data;
            squash_en         = 1'b1;
            // A same-cycle LL result to the same register is older: drop it.
            push              = ll_take && (bus.ll_rd != bus.pipe_rd);
        end else if (!fifo_empty) begin
            // Squashed head still consumes the slot, just without a write.
            pop               = 1'b1;
            reg_write_en_next = head.live;
            rd_addr_next      = head.rd;
            rd_data_next      = head.data;
            push              = ll_take;
        end else if (ll_take) begin
            reg_write_en_next = 1'b1;
            rd_addr_next      = bus.ll_rd;
            rd_data_next      = bus.ll_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_en_reg <= 1'b0;
            rd_addr_reg      <= '0;
            rd_data_reg      <= '0;
        end else begin
            reg_write_en_reg <= reg_write_en_next;
            rd_addr_reg      <= rd_addr_next;
            rd_data_reg      <= rd_data_next;
        end
    end

    wb_ll_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ll_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_rd      (bus.ll_rd),
        .push_data    (bus.ll_data),
        .pop          (pop),
        .squash_en    (squash_en),
        .squash_rd    (bus.pipe_rd),
        .head         (head),
        .count        (fifo_count),
        .pending_mask (pending_mask)
    );

    assign bus.ll_ready     = ll_ready;
    assign bus.reg_write_en = reg_write_en_reg;
    assign bus.rd_addr      = rd_addr_reg;
    assign bus.rd_data      = rd_data_reg;
    assign bus.fifo_count   = fifo_count;
    assign bus.pending_mask = pending_mask;

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-side master for the 32-entry register file's single write port. Merges the in-order pipeline writeback stream with results from long-latency units (loads, multi-cycle multiply/divide) into one registered `reg_write_en`/`rd_addr`/`rd_data` stream. The pipeline always has priority; long-latency results are buffered in a small FIFO and drained in idle write slots, with WAW squashing and a pending-register mask for the hazard unit.

## Interface
- `DATA_WIDTH`, 32: register data width.
- `ADDR_WIDTH`, 5: register index width; x0 is index 0.
- `DEPTH`, 4: long-latency FIFO entries; power of 2, ≥2.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  **asynchronous, active-high** reset.
- `pipe_we`  in  1  pipeline WB write request; never stalled.
- `pipe_rd`  in  ADDR_WIDTH  pipeline destination register.
- `pipe_data`  in  DATA_WIDTH  pipeline result.
- `ll_valid`  in  1  long-latency result valid.
- `ll_ready`  out  1  FIFO can accept; `ll_valid && ll_ready` is a transfer.
- `ll_rd`  in  ADDR_WIDTH  long-latency destination register.
- `ll_data`  in  DATA_WIDTH  long-latency result.
- `reg_write_en`  out  1  to register file write enable.
- `rd_addr`  out  ADDR_WIDTH  to register file write address.
- `rd_data`  out  DATA_WIDTH  to register file write data.
- `pending_mask`  out  2**ADDR_WIDTH  bit r set while a live FIFO entry targets r.
- `fifo_count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Pipe slot is *busy* when `pipe_we && pipe_rd != 0`; otherwise *free*. A pipe write to x0 is discarded.
- An LL transfer with `ll_rd == 0` completes the handshake and is discarded.
- Busy slot: output register loads the pipe write. Every live FIFO entry with `rd == pipe_rd` is squashed (live bit cleared). A same-cycle LL transfer with `ll_rd == pipe_rd` is discarded (it is older). Any other LL transfer is enqueued.
- Free slot, FIFO non-empty: head is popped into the output register. `reg_write_en` = head live bit; a squashed head consumes the slot with no write. A same-cycle LL transfer is enqueued behind it, preserving order.
- Free slot, FIFO empty: an LL transfer bypasses directly into the output register. If there is no transfer, `reg_write_en` = 0.
- `ll_ready` = `fifo_count < DEPTH`. It is derived from state only, with no combinational path from inputs. When full, the block is not ready even in a pop cycle.
- `pending_mask` = OR of one-hot(rd) over live FIFO entries. It reflects state after the edge.

## Timing
- Reset values: `reg_write_en` 0, `rd_addr` 0, `rd_data` 0, `fifo_count` 0, `pending_mask` 0, `ll_ready` 1. All FIFO live bits are cleared.
- Reset mid-operation discards all buffered and in-flight results. No write is issued during reset.
- Latency:
  - Pipe write: reaches `reg_write_en` 1 cycle later.
  - LL bypass: 1 cycle.
  - Buffered LL: 1 cycle after the first free slot at which it is head.
- At most one register write per cycle. Writes are never emitted to x0.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves `fifo_count` unchanged.
- Squash and enqueue in the same cycle act on pre-edge FIFO contents. A newly enqueued entry is always live.

## Configuration
- `WB_ARB_PENDING_MASK_EN`:
  - Defined: `pending_mask` is generated as above.
  - Undefined: `pending_mask` is tied to 0 and its comparator logic is removed. The hazard unit must then stall conservatively on `fifo_count != 0`.
- Squashing is unconditional in both configurations.

## Structure
- Package `wb_pkg`:
  - `wb_entry_t` struct {live, rd, data}.
  - Constant `WB_X0 = 0`.
  - Default `WB_LL_DEPTH = 4`.
- Sub-module `wb_ll_fifo`: holds the entry array, pointers, count, and parallel rd-compare squash port. It also produces `pending_mask`. The top module holds the slot arbitration and the output register.

## Test plan
- Reset with FIFO holding 3 entries → next cycle all outputs at reset values, `ll_ready` = 1.
- `pipe_we` = 1, rd = 5, data = 0xA5A5_0001, no LL → 1 cycle later `reg_write_en` = 1, `rd_addr` = 5, `rd_data` = 0xA5A5_0001.
- Pipe busy for 5 cycles while LL sends rd = 7, 8, 9, 10, 11:
  - `ll_ready` drops after the 4th transfer.
  - `fifo_count` = 4.
  - `pending_mask` bits 7–10 are set.
  - After the pipe goes idle, writes 7, 8, 9, 10 appear in order.
- FIFO holds rd = 3, then pipe writes rd = 3 → FIFO entry squashed, `pending_mask[3]` = 0. Its drain slot shows `reg_write_en` = 0, and register 3 keeps the pipe value.
- Same cycle: pipe rd = 4 and LL rd = 4 → only the pipe write issues; LL is accepted and dropped, `fifo_count` unchanged.
- Pipe writes rd = 0, and an LL with rd = 0 is sent → no `reg_write_en` ever. The pipe x0 write frees the slot, so a queued head drains that cycle.
